ssd_scan_ctl: RTL and testbench

- Four-digit seven-segment display scan controller. It is the consumer of the 2-bit scan-phase bus produced by the team's frequency divider.
- Takes a 4-digit BCD frame plus decimal points through a load pulse. Double-buffers the frame so a displayed frame never tears.
- On every scan-phase change, inserts a programmable blanking (anti-ghost) interval, then drives the selected digit's enable and segment pattern.
- Sits between the counter/datapath logic and the board display pins.

---
 rtl/ssd_scan_ctl_pkg.sv | 43 ++++
 rtl/ssd_scan_ctl_bcd_to_ssd.sv | 38 +++
 rtl/ssd_scan_ctl.sv | 144 ++++++++++++++
 tb/tb_ssd_scan_ctl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_scan_ctl_pkg.sv
// ssd_scan_ctl_pkg: shared constants for the four-digit seven-segment scan
// controller.
//   - Active-low segment patterns {a,b,c,d,e,f,g,dp} with the dp bit off.
//   - Scan FSM state encoding.
//   - Active-low digit enable patterns and a select-to-enable helper.
package ssd_scan_ctl_pkg;

  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  localparam logic [3:0] DIG_EN_0 = 4'b1110;
  localparam logic [3:0] DIG_EN_1 = 4'b1101;
  localparam logic [3:0] DIG_EN_2 = 4'b1011;
  localparam logic [3:0] DIG_EN_3 = 4'b0111;
  localparam logic [3:0] DIG_OFF  = 4'b1111;

  function automatic logic [3:0] dig_en(input logic [1:0] sel);
    logic [3:0] en;
    case (sel)
      2'd0:    en = DIG_EN_0;
      2'd1:    en = DIG_EN_1;
      2'd2:    en = DIG_EN_2;
      default: en = DIG_EN_3;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/ssd_scan_ctl_bcd_to_ssd.sv
// bcd_to_ssd: combinational BCD-to-seven-segment decoder, active-low.
//   code_i  : 4-bit digit code; 10..15 render as a dash.
//   blank_i : force all segments off (dp still honoured).
//   dp_i    : 1 lights the decimal point (clears bit 0).
//   seg_o   : {a,b,c,d,e,f,g,dp} pattern, active-low.
module bcd_to_ssd
  import ssd_scan_ctl_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  logic [7:0] pat;

  always_comb begin
    pat = SEG_BLANK;
    if (!blank_i) begin
      case (code_i)
        4'd0:    pat = SEG_0;
        4'd1:    pat = SEG_1;
        4'd2:    pat = SEG_2;
        4'd3:    pat = SEG_3;
        4'd4:    pat = SEG_4;
        4'd5:    pat = SEG_5;
        4'd6:    pat = SEG_6;
        4'd7:    pat = SEG_7;
        4'd8:    pat = SEG_8;
        4'd9:    pat = SEG_9;
        default: pat = SEG_DASH;
      endcase
    end
  end

  assign seg_o = {pat[7:1], pat[0] & ~dp_i};

endmodule

// File: rtl/ssd_scan_ctl.sv
// ssd_scan_ctl: four-digit seven-segment scan controller.
//   clk, rst_n  : clock, asynchronous active-low reset.
//   scan_sel    : scan phase from the divider; k selects digit k (0 = rightmost).
//   bcd_in      : frame, [15:12] = digit 3 ... [3:0] = digit 0.
//   dp_in       : decimal point per digit, 1 = lit.
//   load        : strobe capturing bcd_in/dp_in into the pending buffer.
//   lz_en       : leading-zero suppression enable.
//   ftsd_ctl    : registered active-low digit enables.
//   segs        : registered active-low {a..g,dp}.
//   frame_tick  : pulse after a pending frame becomes active.
// A pending frame only becomes active when the scan wraps back to digit 0,
// so a displayed frame never mixes old and new digits. Every phase change
// is followed by DEAD_CYC cycles with all digits off.
module ssd_scan_ctl
  import ssd_scan_ctl_pkg::*;
#(
  parameter int DEAD_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  scan_sel,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        lz_en,
  output logic [3:0]  ftsd_ctl,
  output logic [7:0]  segs,
  output logic        frame_tick
);

  localparam int CNT_W = ($clog2(DEAD_CYC + 1) < 1) ? 1 : $clog2(DEAD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD_CYC);

  logic [1:0]       sel_q, sel_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      act_bcd_q, act_bcd_d, pend_bcd_q;
  logic [3:0]       act_dp_q, act_dp_d, pend_dp_q;
  logic             pend_vld_q;
  logic [3:0]       ftsd_q, ftsd_d;
  logic [7:0]       segs_q, segs_d;
  logic             tick_q;

  logic             chg, commit, show_d;
  logic [3:0][3:0]  nib;
  logic [3:0]       lead_zero;
  logic [7:0]       seg_pat;

  assign chg    = (scan_sel != sel_q);
  assign sel_d  = chg ? scan_sel : sel_q;
  assign commit = chg && (scan_sel == 2'b00) && pend_vld_q;

  // The output registers are loaded from the frame that will be active
  // after this edge, so a committed frame is visible without extra delay.
  assign act_bcd_d = commit ? pend_bcd_q : act_bcd_q;
  assign act_dp_d  = commit ? pend_dp_q  : act_dp_q;

  // A digit is a leading zero when it and every digit to its left are 0.
  // The units digit is always shown.
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign nib[gi] = act_bcd_d[4*gi +: 4];
    if (gi == 0) begin : g_units
      assign lead_zero[gi] = 1'b0;
    end else begin : g_upper
      assign lead_zero[gi] = (act_bcd_d[15:4*gi] == '0);
    end
  end

  bcd_to_ssd u_dec (
    .code_i  (nib[sel_d]),
    .blank_i (lz_en & lead_zero[sel_d]),
    .dp_i    (act_dp_d[sel_d]),
    .seg_o   (seg_pat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_BLANK: begin
        if (chg) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_SHOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        if (chg) begin
          state_d = ST_BLANK;
          cnt_d   = CNT_LOAD;
        end
      end
    endcase
  end

  // Outputs are registered, so they look one cycle ahead: the digit is
  // driven on the edge where the counter reaches zero, which places it
  // exactly DEAD_CYC cycles after the change (immediately for DEAD_CYC=0).
  assign show_d = (state_d == ST_SHOW) || (cnt_d == '0);
  assign ftsd_d = show_d ? dig_en(sel_d) : DIG_OFF;
  assign segs_d = show_d ? seg_pat : SEG_BLANK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= 2'b00;
      state_q    <= ST_BLANK;
      cnt_q      <= CNT_LOAD;
      act_bcd_q  <= '0;
      act_dp_q   <= '0;
      pend_bcd_q <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      ftsd_q     <= DIG_OFF;
      segs_q     <= SEG_BLANK;
      tick_q     <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        act_bcd_q <= pend_bcd_q;
        act_dp_q  <= pend_dp_q;
      end
      // A load coinciding with a commit refills the pending buffer.
      if (load) begin
        pend_bcd_q <= bcd_in;
        pend_dp_q  <= dp_in;
        pend_vld_q <= 1'b1;
      end else if (commit) begin
        pend_vld_q <= 1'b0;
      end
      ftsd_q <= ftsd_d;
      segs_q <= segs_d;
      tick_q <= commit;
    end
  end

  assign ftsd_ctl   = ftsd_q;
  assign segs       = segs_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_ctl.sv
// Bench for ssd_scan_ctl: two instances (16 and 0 blanking cycles) share
// the same stimulus and are compared every cycle with a frame-level model.
module tb_ssd_scan_ctl;

  localparam int DA = 16;
  localparam int DB = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  scan_sel = 2'd0;
  logic [15:0] bcd_in = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        lz_en = 1'b0;

  logic [3:0]  ftsd_a, ftsd_b;
  logic [7:0]  segs_a, segs_b;
  logic        tick_a, tick_b;

  always #5 clk = ~clk;

  ssd_scan_ctl #(.DEAD_CYC(DA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .scan_sel(scan_sel), .bcd_in(bcd_in),
    .dp_in(dp_in), .load(load), .lz_en(lz_en),
    .ftsd_ctl(ftsd_a), .segs(segs_a), .frame_tick(tick_a)
  );

  ssd_scan_ctl #(.DEAD_CYC(DB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .scan_sel(scan_sel), .bcd_in(bcd_in),
    .dp_in(dp_in), .load(load), .lz_en(lz_en),
    .ftsd_ctl(ftsd_b), .segs(segs_b), .frame_tick(tick_b)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Frame-level reference: what is shown is a function of the active frame,
  // the selected digit and how many edges have passed since the last phase
  // change.
  logic [7:0]  seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h09, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD, 8'hFD};
  logic [1:0]  m_sel;
  logic [15:0] m_act_bcd, m_pend_bcd;
  logic [3:0]  m_act_dp, m_pend_dp;
  logic        m_pvld, m_tick;
  int          m_edge, m_last_chg;

  task automatic model_reset();
    m_sel = 2'd0; m_act_bcd = '0; m_pend_bcd = '0; m_act_dp = '0; m_pend_dp = '0;
    m_pvld = 1'b0; m_tick = 1'b0; m_edge = 0; m_last_chg = 0;
  endtask

  task automatic model_edge();
    logic chg, commit;
    m_edge++;
    chg    = (scan_sel != m_sel);
    commit = chg && (scan_sel == 2'd0) && m_pvld;
    if (chg) begin
      m_last_chg = m_edge;
      m_sel = scan_sel;
    end
    if (commit) begin
      m_act_bcd = m_pend_bcd;
      m_act_dp  = m_pend_dp;
    end
    if (load) begin
      m_pend_bcd = bcd_in; m_pend_dp = dp_in; m_pvld = 1'b1;
    end else if (commit) begin
      m_pvld = 1'b0;
    end
    m_tick = commit;
  endtask

  function automatic logic [7:0] exp_segs(input logic [1:0] k, input logic lz);
    logic [15:0] upper;
    logic [7:0]  p;
    upper = m_act_bcd >> (4 * int'(k));
    if (lz && k != 2'd0 && upper == 16'h0) p = 8'hFF;
    else p = seg_tab[upper[3:0]];
    if (m_act_dp[k]) p[0] = 1'b0;
    return p;
  endfunction

  task automatic check_all();
    logic [3:0] ef;
    logic [7:0] es;
    logic       blank_a, blank_b;
    ef = 4'hF;
    ef[m_sel] = 1'b0;
    es = exp_segs(m_sel, lz_en);
    blank_a = (m_edge - m_last_chg) < DA;
    blank_b = (m_edge - m_last_chg) < DB;
    chk("ftsd_a", 32'(ftsd_a), blank_a ? 32'hF : 32'(ef));
    chk("segs_a", 32'(segs_a), blank_a ? 32'hFF : 32'(es));
    chk("tick_a", 32'(tick_a), 32'(m_tick));
    chk("ftsd_b", 32'(ftsd_b), blank_b ? 32'hF : 32'(ef));
    chk("segs_b", 32'(segs_b), blank_b ? 32'hFF : 32'(es));
    chk("tick_b", 32'(tick_b), 32'(m_tick));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ftsd_a"}, 32'(ftsd_a), 32'hF);
    chk({tag, "_segs_a"}, 32'(segs_a), 32'hFF);
    chk({tag, "_tick_a"}, 32'(tick_a), 32'h0);
    chk({tag, "_ftsd_b"}, 32'(ftsd_b), 32'hF);
    chk({tag, "_segs_b"}, 32'(segs_b), 32'hFF);
    chk({tag, "_tick_b"}, 32'(tick_b), 32'h0);
  endtask

  task automatic cyc(input logic [1:0] sel, input logic ld, input logic [15:0] bcd,
                     input logic [3:0] dp);
    scan_sel = sel; load = ld; bcd_in = bcd; dp_in = dp;
    if (ld) $display("load bcd=%h dp=%b sel=%0d lz=%0d", bcd, dp, sel, lz_en);
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic dwell(input logic [1:0] sel, input int n);
    repeat (n) cyc(sel, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic scan_frame(input int n);
    for (int s = 0; s < 4; s++) dwell(2'(s), n);
  endtask

  function automatic logic [15:0] rand_frame();
    logic [15:0] f;
    for (int d = 0; d < 4; d++) begin
      case ($urandom_range(0, 4))
        0, 1:    f[4*d +: 4] = 4'd0;
        2, 3:    f[4*d +: 4] = 4'($urandom_range(1, 9));
        default: f[4*d +: 4] = 4'($urandom_range(10, 15));
      endcase
    end
    return f;
  endfunction

  initial begin
    model_reset();
    // Reset held with random inputs.
    repeat (4) begin
      scan_sel = 2'($urandom); load = 1'($urandom); bcd_in = 16'($urandom);
      dp_in = 4'($urandom); lz_en = 1'($urandom);
      @(posedge clk);
      #1;
      chk_reset("rst");
    end
    scan_sel = 2'd0; load = 1'b0; lz_en = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Empty frame, no suppression: every digit shows 0.
    dwell(2'd0, 20);
    scan_frame(20);

    // Frame 1234 with dp on digit 2; committed at the next digit-0 phase.
    cyc(2'd3, 1'b1, 16'h1234, 4'b0100);
    scan_frame(20);
    scan_frame(20);

    // Blanking restart: change 0->1, then 1->2 after 5 cycles.
    dwell(2'd0, 20);
    dwell(2'd1, 5);
    dwell(2'd2, 20);
    dwell(2'd3, 20);

    // Tearing: 1111 shown, 2222 loaded on digit 2, appears from digit 0.
    cyc(2'd3, 1'b1, 16'h1111, 4'b0000);
    scan_frame(20);
    dwell(2'd0, 20);
    dwell(2'd1, 20);
    cyc(2'd2, 1'b1, 16'h2222, 4'b0000);
    dwell(2'd2, 19);
    dwell(2'd3, 20);
    scan_frame(20);

    // Load coincident with the commit edge.
    cyc(2'd3, 1'b1, 16'h5678, 4'b0001);
    dwell(2'd3, 3);
    cyc(2'd0, 1'b1, 16'h9012, 4'b1000);
    dwell(2'd0, 19);
    for (int s = 1; s < 4; s++) dwell(2'(s), 20);
    scan_frame(20);

    // Leading-zero suppression.
    lz_en = 1'b1;
    cyc(2'd3, 1'b1, 16'h0007, 4'b0000);
    scan_frame(20);
    cyc(2'd3, 1'b1, 16'h0000, 4'b0000);
    scan_frame(20);
    cyc(2'd3, 1'b1, 16'h00A0, 4'b0100);
    scan_frame(20);
    cyc(2'd3, 1'b1, 16'h0305, 4'b0000);
    scan_frame(20);

    // Randomized traffic.
    repeat (250) begin
      logic [1:0] sel;
      int n;
      lz_en = 1'($urandom);
      sel = 2'($urandom);
      n = $urandom_range(1, 22);
      for (int i = 0; i < n; i++)
        cyc(sel, ($urandom_range(0, 15) == 0), rand_frame(), 4'($urandom));
    end

    // Asynchronous reset while a pending frame waits to be committed.
    lz_en = 1'b0;
    dwell(2'd1, 20);
    cyc(2'd1, 1'b1, 16'h4321, 4'b1111);
    dwell(2'd2, 20);
    #2 rst_n = 1'b0;
    #1 chk_reset("arst");
    repeat (3) begin
      scan_sel = 2'($urandom); load = 1'($urandom); bcd_in = 16'($urandom);
      @(posedge clk);
      #1;
      chk_reset("arst_hold");
    end
    scan_sel = 2'd0; load = 1'b0;
    rst_n = 1'b1;
    model_reset();
    dwell(2'd0, 20);
    scan_frame(20);
    scan_frame(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
